mem_stage_access_unit: RTL

- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns MEMemRead/MEMemWrite, the address (MEResult), the store data (MERD2) and the size select (MEReadDMMux) into a req/ack transaction on the data-memory port.
- Stalls the pipeline until the access completes, then returns size-extracted, sign- or zero-extended load data to the MEM/WB path.
- Misaligned accesses, conflicting requests and memory timeouts are flagged with one-cycle error pulses.

---
 rtl/mem_stage_access_unit.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_access_unit.sv
// ============================================================================
// Module : mem_stage_access_unit
// Brief  : MEM-stage data-memory access sequencer (req/ack, stall, load extract)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MEMemRead,
  input  logic        MEMemWrite,
  input  logic [1:0]  MEReadDMMux,
  input  logic        MEUnsigned,
  input  logic [31:0] MEResult,
  input  logic [31:0] MERD2,
  output logic        DMReq,
  output logic        DMWe,
  output logic [31:0] DMAddr,
  output logic [3:0]  DMByteEn,
  output logic [31:0] DMWData,
  input  logic        DMAck,
  input  logic [31:0] DMRData,
  output logic        Stall,
  output logic [31:0] MELoadData,
  output logic        MisalignErr,
  output logic        TimeoutErr
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_done   = 2'd2;

  localparam logic [1:0] c_sz_half = 2'd1;
  localparam logic [1:0] c_sz_byte = 2'd2;

  localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**CNT_WIDTH) - 1) begin : g_param_check
      $error("mem_stage_access_unit: TIMEOUT_CYCLES out of range for CNT_WIDTH");
    end
  endgenerate

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [31:0] r_load_data;
  logic        r_misalign_err;
  logic        r_timeout_err;

  logic        w_op;
  logic        w_conflict;
  logic        w_aligned;
  logic        w_accept;
  logic        w_bad;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_in_idle;
  logic        w_in_access;
  logic        w_latch;
  logic        w_complete;
  logic        w_expire;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldata;

  // Request decode from the EX/MEM register.
  assign w_op       = MEMemRead ^ MEMemWrite;
  assign w_conflict = MEMemRead & MEMemWrite;

  always_comb begin
    w_aligned = 1'b0;
    w_be      = 4'b0000;
    w_wdata   = 32'h0;
    case (MEReadDMMux)
      c_sz_half: begin
        w_aligned = ~MEResult[0];
        w_be      = MEResult[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{MERD2[15:0]}};
      end
      c_sz_byte: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << MEResult[1:0];
        w_wdata   = {4{MERD2[7:0]}};
      end
      default: begin
        w_aligned = (MEResult[1:0] == 2'b00);
        w_be      = 4'b1111;
        w_wdata   = MERD2;
      end
    endcase
  end

  assign w_accept = w_op & w_aligned;
  assign w_bad    = w_conflict | (w_op & ~w_aligned);

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          w_state_nxt = c_st_access;
        end
      end
      c_st_access: begin
        if (DMAck || (r_cnt == c_cnt_last)) begin
          w_state_nxt = c_st_done;
        end
      end
      c_st_done: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Output logic; Stall is gated by Rst so a held request cannot leak through reset.
  always_comb begin
    w_in_idle   = (r_state == c_st_idle);
    w_in_access = (r_state == c_st_access);
    DMReq       = w_in_access;
    DMWe        = w_in_access & r_we;
    DMByteEn    = w_in_access ? r_be : 4'b0000;
    Stall       = ~Rst & (w_in_access | (w_in_idle & w_accept));
    w_latch     = w_in_idle & w_accept;
    w_complete  = w_in_access & DMAck;
    w_expire    = w_in_access & ~DMAck & (r_cnt == c_cnt_last);
  end

  assign DMAddr      = r_addr;
  assign DMWData     = r_wdata;
  assign MELoadData  = r_load_data;
  assign MisalignErr = r_misalign_err;
  assign TimeoutErr  = r_timeout_err;

  // Load lane extraction uses the address latched at accept time.
  always_comb begin
    w_byte = 8'h00;
    case (r_lane)
      2'd0:    w_byte = DMRData[7:0];
      2'd1:    w_byte = DMRData[15:8];
      2'd2:    w_byte = DMRData[23:16];
      default: w_byte = DMRData[31:24];
    endcase
    w_half  = r_lane[1] ? DMRData[31:16] : DMRData[15:0];
    w_ldata = DMRData;
    case (r_size)
      c_sz_half: w_ldata = {{16{~r_unsigned & w_half[15]}}, w_half};
      c_sz_byte: w_ldata = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      default:   w_ldata = DMRData;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_addr     <= 32'h0;
      r_we       <= 1'b0;
      r_be       <= 4'b0000;
      r_wdata    <= 32'h0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
    end else if (w_latch) begin
      r_addr     <= {MEResult[31:2], 2'b00};
      r_we       <= MEMemWrite;
      r_be       <= w_be;
      r_wdata    <= w_wdata;
      r_size     <= MEReadDMMux;
      r_unsigned <= MEUnsigned;
      r_lane     <= MEResult[1:0];
    end
  end

  // Counter runs only while waiting for the ack.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cnt <= '0;
    end else if (w_in_access && !DMAck && (r_cnt != c_cnt_last)) begin
      r_cnt <= r_cnt + c_cnt_one;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_load_data    <= 32'h0;
      r_misalign_err <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_misalign_err <= w_in_idle & w_bad;
      r_timeout_err  <= w_expire;
      if (w_complete && !r_we) begin
        r_load_data <= w_ldata;
      end else if (w_expire && !r_we) begin
        r_load_data <= 32'h0;
      end
    end
  end

endmodule

`default_nettype wire
